hidden_weight_loader: RTL

HIDDEN_WEIGHT_LOADER -- requirements
Module: hidden_weight_loader

---
 rtl/hidden_weight_loader.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/hidden_weight_loader.sv
// hidden_weight_loader: streams NUM_NEURONS*NUM_INPUTS weight bytes into
// local storage and presents GROUP neurons' weights for one input index.
// Optional feature macro: HWL_CHECKSUM_EN adds a trailing checksum byte
// (CHK state) and drives err; without it err is tied low.
module hidden_weight_loader #(
  parameter int NUM_INPUTS  = 62,
  parameter int NUM_NEURONS = 20,
  parameter int GROUP       = 10,
  parameter int W           = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [W-1:0]       in_data,
  output logic               in_ready,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic [5:0]         rd_input_sel,
  input  logic               rd_t,
  output logic [GROUP*W-1:0] rd_w
);

  // state | meaning
  // IDLE  | no image loaded since reset
  // LOAD  | accepting weight bytes, addr_q is the next write address
  // CHK   | waiting for the checksum byte (checksum build only)
  // DONE  | storage holds a complete image
  localparam int DEPTH = NUM_NEURONS * NUM_INPUTS;
  localparam int AW    = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

`ifdef HWL_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CHK = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we;
  logic [W-1:0]    wmem [DEPTH];

`ifdef HWL_CHECKSUM_EN
  logic [7:0]      sum_q, sum_d;
  logic            err_q, err_d;
`endif

  // state and address registers; storage is deliberately left out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
`ifdef HWL_CHECKSUM_EN
      sum_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
`ifdef HWL_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  // next state, write enable and address/sum updates
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we      = 1'b0;
`ifdef HWL_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = '0;
`ifdef HWL_CHECKSUM_EN
          sum_d   = 8'd0;
          err_d   = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (in_valid) begin
          we     = 1'b1;
          addr_d = addr_q + AW'(1);
`ifdef HWL_CHECKSUM_EN
          sum_d  = sum_q + 8'(in_data);
          if (addr_q == LAST_ADDR) state_d = CHK;
`else
          if (addr_q == LAST_ADDR) state_d = DONE;
`endif
        end
      end
`ifdef HWL_CHECKSUM_EN
      CHK: begin
        if (in_valid) begin
          err_d   = (sum_q + 8'(in_data)) != 8'd0;
          state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // weight storage write port; a same-cycle read still sees the old value
  always_ff @(posedge clk) begin
    if (we) wmem[addr_q] <= in_data;
  end

  // status outputs decoded from state
  always_comb begin
    busy     = (state_q != IDLE) && (state_q != DONE);
    in_ready = busy;
    done     = (state_q == DONE);
`ifdef HWL_CHECKSUM_EN
    err      = err_q;
`else
    err      = 1'b0;
`endif
  end

  // zero-latency group read; out-of-range input or address reads as 0
  always_comb begin
    rd_w = '0;
    for (int k = 0; k < GROUP; k++) begin
      int idx;
      idx = (GROUP * int'(rd_t) + k) * NUM_INPUTS + int'(rd_input_sel);
      if ((int'(rd_input_sel) < NUM_INPUTS) && (idx < DEPTH))
        rd_w[W*k +: W] = wmem[idx[AW-1:0]];
    end
  end

endmodule
